// File: rtl/mips_mem_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mips_mem_pkg
// Brief    : Shared types and defaults for the data-memory side of the pipeline.
// Revision : 1.0
// ============================================================================
package mips_mem_pkg;

    localparam int SB_DEPTH_DEFAULT = 4;

    typedef struct packed {
        logic [29:0] addr;
        logic [31:0] data;
        logic        sb;
    } sb_entry_t;

endpackage
`default_nettype wire

// File: rtl/sb_fwd_match.sv
`default_nettype none
// ============================================================================
// Module   : sb_fwd_match
// Brief    : Youngest-match search of occupied store-buffer entries.
// Revision : 1.0
// ============================================================================
module sb_fwd_match
    import mips_mem_pkg::*;
#(
    parameter int DEPTH = SB_DEPTH_DEFAULT
) (
    input  sb_entry_t                entries [DEPTH],
    input  logic [$clog2(DEPTH)-1:0] head,
    input  logic [$clog2(DEPTH):0]   count,
    input  logic [29:0]              ld_word,
    output logic                     hit,
    output logic                     hit_is_byte,
    output logic [31:0]              hit_data
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;

    logic [c_PTR_W-1:0] w_idx;

    // Walk oldest to youngest so the last match seen wins.
    always_comb begin
        hit         = 1'b0;
        hit_is_byte = 1'b0;
        hit_data    = '0;
        w_idx       = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_idx = head + c_PTR_W'(i);
            if ((c_CNT_W'(i) < count) && (entries[w_idx].addr == ld_word)) begin
                hit         = 1'b1;
                hit_is_byte = entries[w_idx].sb;
                hit_data    = entries[w_idx].data;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/store_buffer.sv
`default_nettype none
// ============================================================================
// Module   : store_buffer
// Brief    : Posted-write FIFO between MEM and dmem; owns the single dmem port.
// Revision : 1.0
// ============================================================================
module store_buffer
    import mips_mem_pkg::*;
#(
    parameter int DEPTH = SB_DEPTH_DEFAULT
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   st_valid,
    input  logic                   st_sb,
    input  logic [31:0]            st_addr,
    input  logic [31:0]            st_data,
    output logic                   st_ready,
    input  logic                   ld_valid,
    input  logic [31:0]            ld_addr,
    output logic [31:0]            ld_data,
    output logic                   ld_stall,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count,
    output logic                   dm_we,
    output logic                   dm_sb,
    output logic [31:0]            dm_a,
    output logic [31:0]            dm_wd,
    input  logic [31:0]            dm_rd
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;

    sb_entry_t          r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_head;
    logic [c_PTR_W-1:0] r_tail;
    logic [c_CNT_W-1:0] r_count;

    sb_entry_t   w_head_ent;
    sb_entry_t   w_new_ent;
    logic        w_hit;
    logic        w_hit_is_byte;
    logic [31:0] w_hit_data;
    logic        w_enq;
    logic        w_deq;
    logic        w_ld_port;
    logic        w_unused_st_lsb;

    sb_fwd_match #(
        .DEPTH       (DEPTH)
    ) u_match (
        .entries     (r_mem),
        .head        (r_head),
        .count       (r_count),
        .ld_word     (ld_addr[31:2]),
        .hit         (w_hit),
        .hit_is_byte (w_hit_is_byte),
        .hit_data    (w_hit_data)
    );

    assign w_head_ent      = r_mem[r_head];
    assign w_new_ent       = '{addr: st_addr[31:2], data: st_data, sb: st_sb};
    assign w_unused_st_lsb = ^st_addr[1:0];

    assign count    = r_count;
    assign empty    = (r_count == '0);
    assign st_ready = (r_count != c_CNT_W'(DEPTH));

    assign ld_stall = ld_valid && w_hit && w_hit_is_byte;
    assign ld_data  = (ld_valid && w_hit && !w_hit_is_byte) ? w_hit_data : dm_rd;

    assign w_enq     = st_valid && st_ready;
    // Reset gates the drain so nothing reaches dmem in the reset cycle.
    assign w_deq     = !reset && !empty && (!ld_valid || ld_stall);
    assign w_ld_port = ld_valid && !ld_stall;

    assign dm_we = w_deq;
    assign dm_sb = w_deq && w_head_ent.sb;
    assign dm_a  = w_deq     ? {w_head_ent.addr, 2'b00} :
                   w_ld_port ? ld_addr : '0;
    assign dm_wd = w_deq ? w_head_ent.data : '0;

    always_ff @(posedge clk) begin
        if (w_enq && !reset) begin
            r_mem[r_tail] <= w_new_ent;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_enq) begin
                r_tail <= r_tail + c_PTR_W'(1);
            end
            if (w_deq) begin
                r_head <= r_head + c_PTR_W'(1);
            end
            r_count <= r_count + c_CNT_W'(w_enq) - c_CNT_W'(w_deq);
        end
    end

    a_st_ld_exclusive: assert property (@(posedge clk) disable iff (reset) !(st_valid && ld_valid))
        else $warning("store_buffer: store and load presented in the same cycle");

endmodule
`default_nettype wire

// File: doc/store_buffer.md
# store_buffer

Posted-write buffer between the MEM stage and data memory. Stores from the pipeline are captured into a small FIFO and retired to dmem one per cycle whenever the dmem port is not needed by a load. Loads search the buffer and receive forwarded data on a word hit. Loads stall when the youngest matching entry is a byte store. The block owns the single dmem port: it muxes the dmem address, write data, we and sb.

## Interface
Parameters:
- DEPTH, 4, number of buffered stores; power of two, minimum 2.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high.
- st_valid  in  1  MEM stage presents a store this cycle.
- st_sb  in  1  1 = byte store (bits 7:0), 0 = word store.
- st_addr  in  32  store byte address.
- st_data  in  32  store data.
- st_ready  out  1  buffer can accept a store; upstream holds st_* while st_valid && !st_ready.
- ld_valid  in  1  MEM stage presents a load this cycle.
- ld_addr  in  32  load byte address.
- ld_data  out  32  load result to the pipeline.
- ld_stall  out  1  load must be held; the pipeline freezes MEM and earlier stages.
- empty  out  1  no pending stores; used for halt and drain checks.
- count  out  $clog2(DEPTH)+1  number of occupied entries.
- dm_we, dm_sb  out  1  dmem write enable and byte-store select.
- dm_a, dm_wd  out  32  dmem address and write data.
- dm_rd  in  32  dmem read data, combinational from dm_a.

## Operation
- Storage: circular FIFO of {addr[31:2], data, sb} entries, with head pointer, tail pointer and count.
- Enqueue: when st_valid && st_ready, the store is written at tail on the clock edge, and tail and count advance.
- st_ready = (count != DEPTH).
- A simultaneous drain does not free space in the same cycle: there is no full-bypass.
- Drain: dm_we = !empty && (!ld_valid || ld_stall).
  - When dm_we is 1, dm_a = {head.addr, 2'b00}, dm_wd = head.data and dm_sb = head.sb.
  - On that edge the head entry retires, and head and count advance.
- Load port: when ld_valid && !ld_stall, dm_a = ld_addr, dm_we = 0 and dm_sb = 0.
- Idle: when neither a load nor a drain is active, dm_a = 0 and dm_wd = 0.
- Match: an occupied entry matches when its addr == ld_addr[31:2]. The youngest matching entry (closest to tail) decides the result:
  - youngest match is a word store: forward that entry's data, ld_data = entry data, ld_stall = 0.
  - youngest match is a byte store: ld_stall = 1; the drain proceeds that cycle. The stall repeats until no byte-store match remains.
  - no match: ld_data = dm_rd.
- Byte-store semantics match dmem: only bits 7:0 of the addressed word are replaced, regardless of addr[1:0].
- Count arithmetic: count_next = count + enq − deq, where enq and deq are 1-bit. Pointers wrap modulo DEPTH.
- A simultaneous enqueue and drain leaves count unchanged.
- st_valid && ld_valid in the same cycle is illegal (single MEM stage). An assertion flags it; the load takes the port and the store is still enqueued if st_ready is 1.

## Timing
- Reset values:
  - count = 0, head = tail = 0.
  - st_ready = 1, empty = 1, ld_stall = 0.
  - dm_we = 0, dm_sb = 0, dm_a = 0, dm_wd = 0.
- Reset mid-operation discards all pending stores; no dmem write occurs in the reset cycle.
- Store-to-load visibility: a store enqueued at edge N is searchable by a load in cycle N+1.
- Drain latency:
  - minimum 1 cycle from enqueue to the dmem write (entry present at edge N, written at edge N+1).
  - back-to-back drains occur at 1 per cycle while there are no loads.
- Load latency: ld_data and ld_stall are combinational in the load cycle; nothing is registered on the load path.
- Full: at count == DEPTH, st_ready is 0 for the whole cycle. It rises in the cycle after the edge on which a drain retires an entry.
- Starvation: continuous non-matching loads block the drain indefinitely. The pipeline issues a non-load cycle when !st_ready.

## Structure
- Shared package mips_mem_pkg holds:
  - typedef sb_entry_t (struct: addr [29:0], data [31:0], sb)
  - localparam SB_DEPTH_DEFAULT = 4
- One sub-module, sb_fwd_match: combinational youngest-match priority search over the entry array. It takes head, count and the load word address, and returns hit, hit_is_byte and hit_data.

## Test plan
- Reset, then sw 0x12345678 @0x8. Expect count = 1, then dm_we = 1 with dm_a = 0x8 and dm_wd = 0x12345678 on the next cycle, then empty = 1.
- sw 0xAAAA0000 @0x4 followed immediately by lw @0x4. Expect ld_data = 0xAAAA0000, ld_stall = 0, dm_we = 0 in the load cycle, and the dmem write in the following cycle.
- Fill the buffer: DEPTH stores while ld_valid is held high on non-matching addresses. Expect st_ready = 0 at count = 4. The 5th store is held until loads stop; then one drain occurs and st_ready returns to 1 one cycle later.
- sw 0x11223344 @0xC, then sb 0xFF @0xC, then lw @0xC. Expect ld_stall = 1 until both entries are drained, then ld_data = 0x112233FF from dmem.
- sb 0x55 @0x0, then sw 0xDEADBEEF @0x0, then lw @0x0. Expect forward 0xDEADBEEF with no stall (the youngest entry is a word store).
- Reset asserted with count = 3. Expect count = 0 and empty = 1 on the next edge, no dm_we pulse, and dmem contents unchanged.
